led_pio_arbiter: RTL and testbench
==================================

# led_pio_arbiter

Two-master Avalon-MM arbiter that shares the single LED PIO slave (14-bit output register at word address 0, 32-bit zero-extended readback) between the Nios II data master and a hardware game-logic master. Runs a three-state sequencer, grants requesters round-robin, and drives the PIO's chipselect/write_n/address/writedata from registers. Returns captured readdata to the winning master by releasing its waitrequest. Sits in the SoC fabric between both masters and the PIO's s1 port.

## Interface
Parameters:
- ADDR_W, 2: PIO address width (word addresses).
- DATA_W, 32: Avalon data width on all ports.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  reset; synchronous, active-high.
- m0_address  in  ADDR_W  Nios master address.
- m0_read  in  1  Nios read request.
- m0_write  in  1  Nios write request.
- m0_writedata  in  DATA_W  Nios write data.
- m0_readdata  out  DATA_W  read return; valid while m0_waitrequest=0.
- m0_waitrequest  out  1  low for exactly one cycle when the m0 transfer completes.
- m1_*  same six ports as m0_*  game-logic master.
- s_address  out  ADDR_W  to PIO address.
- s_chipselect  out  1  to PIO chipselect.
- s_write_n  out  1  to PIO write_n, active-low.
- s_writedata  out  DATA_W  to PIO writedata.
- s_readdata  in  DATA_W  from PIO; combinational in s_address.

## Operation
- States: IDLE, ISSUE, RESP.
- Request of master i: mi_read | mi_write. If both are asserted, the request is treated as a write.
- IDLE
  - If no request, stay in IDLE.
  - Otherwise pick the grant:
    - Only one master requesting: that master wins.
    - Both requesting: the master not granted last wins.
  - Latch the grant, address, write flag and writedata, then go to ISSUE.
- ISSUE
  - s_chipselect=1, s_address and s_writedata come from the latch.
  - s_write_n = ~write flag.
  - Capture s_readdata into the rdata register at the end of the cycle (also on writes; harmless).
  - Go to RESP.
- RESP
  - Granted master sees waitrequest=0 and readdata=rdata.
  - s_chipselect=0, s_write_n=1.
  - Update last-granted to the current grant, then go to IDLE.
- mi_waitrequest = ~(state==RESP && grant==i). It is high in all other cycles, whether or not master i is requesting.
- mi_readdata = rdata for both masters. Only meaningful during that master's RESP cycle.
- A master that drops its request during ISSUE still receives its RESP cycle. The PIO access is already committed.
- Reset (any state, including mid-transaction)
  - State goes to IDLE and the pending transfer is abandoned.
  - The granted master never sees waitrequest low for it.
  - Last-granted is set to m1, so m0 wins the first tie.
  - Output reset values: s_chipselect=0, s_write_n=1, s_address=0, s_writedata=0, rdata=0, m0_waitrequest=1, m1_waitrequest=1.

## Timing
- Request sampled at edge N (state IDLE).
- Edge N+1: state ISSUE; slave strobes are asserted for that cycle.
- Edge N+2: state RESP; waitrequest low and readdata valid for that cycle only.
- The master deasserts or issues its next request after edge N+3.
- Throughput: one transfer per 3 cycles. Back-to-back contending masters alternate (m0, m1, m0, ...).
- A request that is held continuously and appears again in IDLE after its own RESP is a new transfer. Avalon masters drop or change the request after a waitrequest-low cycle.
- The PIO write takes effect at the edge ending ISSUE. Readback of a value written by the previous transfer is correct because the earliest following ISSUE is 3 cycles later.
- All slave-side and master-side outputs are registers or a decode of state/grant only. There is no combinational path from mi_* inputs to any output.

## Structure
- Package led_pio_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - master index constants M0=0, M1=1;
  - the reset value of last-granted (M1).
- Sub-module rr_arb2:
  - Inputs: req[1:0] and last grant.
  - Outputs: one-hot gnt[1:0] and gnt_valid.
  - Purely combinational; reused for future shared slaves (hex PIO, keycode PIO).
- Top level holds the FSM, the request latch and the rdata register.

## Test plan
- m0 write 0x2A5 to address 0 alone:
  - cycle+1: s_chipselect=1, s_write_n=0, s_writedata=0x2A5.
  - cycle+2: m0_waitrequest=0.
  - PIO out_port=0x2A5 afterwards.
- m1 read of address 0 after that write: m1_readdata=0x000002A5 in its RESP cycle. m0_waitrequest stays 1 throughout.
- m0 and m1 request simultaneously from reset:
  - m0 completes at cycle+2 and m1 at cycle+5.
  - Both held continuously: grants alternate m0, m1, m0, m1.
- Read of address 1 while PIO holds 0x3FFF: readdata=0 (PIO decodes only address 0).
- Reset asserted during ISSUE of an m1 write:
  - Next cycle: IDLE, all outputs at reset values, no waitrequest-low cycle for m1.
  - A subsequent tie grants m0.
- m0 asserts read and write together with writedata 0x1: treated as a write, s_write_n=0 in ISSUE, PIO updated to 0x1.

Source files
------------

// File: rtl/led_pio_arb_pkg.sv
// Shared types and constants for the LED PIO arbiter and its round-robin helper.
package led_pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // m0 wins the first tie after reset.
    localparam logic LAST_GNT_RST = M1;

endpackage

// File: rtl/led_pio_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on a tie the one not granted last wins.
module rr_arb2
    import led_pio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt       = 2'b00;
        gnt_valid = |req;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/led_pio_arbiter.sv
// Shares the single LED PIO slave between the Nios data master (m0) and the game-logic master (m1).
// Handshake: a master holds read/write until it sees waitrequest low for exactly one cycle;
// readdata is valid only in that cycle. Every output is a register or a decode of state/grant.
module led_pio_arbiter
    import led_pio_arb_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,

    output logic [1:0]        dbg_state
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_grant;
    logic                r_last;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_gnt_valid;
    logic                w_sel;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};
    assign w_sel = w_gnt[1];

    rr_arb2 u_rr_arb2 (
        .req       (w_req),
        .last_gnt  (r_last),
        .gnt       (w_gnt),
        .gnt_valid (w_gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        s_chipselect   = 1'b0;
        s_write_n      = 1'b1;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                s_chipselect = 1'b1;
                s_write_n    = ~r_wr;
                w_next_state = RESP;
            end
            RESP: begin
                m0_waitrequest = ~(r_grant == M0);
                m1_waitrequest = ~(r_grant == M1);
                w_next_state   = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Read and write together count as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= M0;
            r_last  <= LAST_GNT_RST;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant <= w_sel;
                        r_wr    <= (w_sel == M1) ? m1_write     : m0_write;
                        r_addr  <= (w_sel == M1) ? m1_address   : m0_address;
                        r_wdata <= (w_sel == M1) ? m1_writedata : m0_writedata;
                    end
                end
                ISSUE: begin
                    r_rdata <= s_readdata;
                end
                RESP: begin
                    r_last <= r_grant;
                end
                default: begin
                end
            endcase
        end
    end

    assign s_address   = r_addr;
    assign s_writedata = r_wdata;
    assign m0_readdata = r_rdata;
    assign m1_readdata = r_rdata;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Bench for led_pio_arbiter: a 14-bit LED PIO model on the slave side, transaction-level
// reference model feeding an expected queue, and a monitor that checks every completion.
module tb_led_pio_arbiter;
    import led_pio_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [1:0]  s_address;
    logic        s_chipselect, s_write_n;
    logic [31:0] s_writedata, s_readdata;
    logic [1:0]  dbg_state;

    led_pio_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_chipselect   (s_chipselect),
        .s_write_n      (s_write_n),
        .s_writedata    (s_writedata),
        .s_readdata     (s_readdata),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset / PIO model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [13:0] pio;
    always @(posedge clk) begin
        if (reset) pio <= '0;
        else if (s_chipselect && !s_write_n && s_address == 2'd0) pio <= s_writedata[13:0];
    end
    assign s_readdata = (s_address == 2'd0) ? {18'd0, pio} : 32'd0;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    // {master, PIO value after the transfer, expected readdata}
    logic [46:0] exp_q[$];
    logic [13:0] m_pio  = '0;
    logic        m_last = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_exp(input logic m, input logic wr, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        rd = (a == 2'd0) ? {18'd0, m_pio} : 32'd0;
        if (wr && a == 2'd0) m_pio = d[13:0];
        exp_q.push_back({m, m_pio, rd});
        m_last = m;
    endtask

    always @(negedge clk) begin
        logic [46:0] e;
        logic        act_m;
        if (!reset && (!m0_waitrequest || !m1_waitrequest)) begin
            if (!m0_waitrequest && !m1_waitrequest)
                check("both_waitrequest_low", 1, 0);
            act_m = m0_waitrequest ? 1'b1 : 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_completion", {63'd0, act_m}, 64'hFF);
            end else begin
                e = exp_q.pop_front();
                check("resp_master", {63'd0, act_m}, {63'd0, e[46]});
                check("resp_readdata", act_m ? m1_readdata : m0_readdata, {32'd0, e[31:0]});
                check("pio_value", {50'd0, pio}, {50'd0, e[45:32]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int m, input logic rd, input logic wr, input logic [1:0] a,
                         input logic [31:0] d, output int done);
        bit ok = 0;
        done = -1;
        if (!(rd || wr)) return;
        if (m == 0) begin m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; end
        else        begin m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ((m == 0) ? !m0_waitrequest : !m1_waitrequest) begin
                done = cyc;
                ok   = 1;
                break;
            end
        end
        if (!ok) check((m == 0) ? "m0_timeout" : "m1_timeout", 0, 1);
        @(negedge clk);
        if (m == 0) begin m0_read = 0; m0_write = 0; end
        else        begin m1_read = 0; m1_write = 0; end
    endtask

    // One round: the model orders the requesters, then both drivers run concurrently.
    task automatic run_round(input logic rd0, input logic wr0, input logic [1:0] a0, input logic [31:0] d0,
                             input logic rd1, input logic wr1, input logic [1:0] a1, input logic [31:0] d1,
                             input bit chk_strobe, output int start, output int done0, output int done1);
        logic q0, q1, first;
        int dn0, dn1;
        q0 = rd0 | wr0;
        q1 = rd1 | wr1;
        first = (q0 && q1) ? ~m_last : (q0 ? 1'b0 : 1'b1);
        if (first == 1'b0) begin
            if (q0) push_exp(1'b0, wr0, a0, d0);
            if (q1) push_exp(1'b1, wr1, a1, d1);
        end else begin
            if (q1) push_exp(1'b1, wr1, a1, d1);
            if (q0) push_exp(1'b0, wr0, a0, d0);
        end
        start = cyc;
        fork
            drive(0, rd0, wr0, a0, d0, dn0);
            drive(1, rd1, wr1, a1, d1, dn1);
            begin
                if (chk_strobe) begin
                    @(negedge clk);
                    check("issue_chipselect", {63'd0, s_chipselect}, 1);
                    check("issue_write_n", {63'd0, s_write_n}, 0);
                    check("issue_address", {62'd0, s_address}, {62'd0, first ? a1 : a0});
                    check("issue_writedata", {32'd0, s_writedata}, {32'd0, first ? d1 : d0});
                end
            end
        join
        done0 = dn0;
        done1 = dn1;
    endtask

    task automatic check_reset_outputs();
        check("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
        check("rst_chipselect", {63'd0, s_chipselect}, 0);
        check("rst_write_n", {63'd0, s_write_n}, 1);
        check("rst_address", {62'd0, s_address}, 0);
        check("rst_writedata", {32'd0, s_writedata}, 0);
        check("rst_readdata", {32'd0, m0_readdata}, 0);
        check("rst_m0_wait", {63'd0, m0_waitrequest}, 1);
        check("rst_m1_wait", {63'd0, m1_waitrequest}, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st, d0, d1, cnt;
        reset = 1;
        m0_address = 0; m0_read = 0; m0_write = 0; m0_writedata = 0;
        m1_address = 0; m1_read = 0; m1_write = 0; m1_writedata = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 0;
        @(negedge clk);

        // m0 write alone, strobes one cycle later, completion two cycles later
        run_round(0, 1, 2'd0, 32'h2A5, 0, 0, 2'd0, 32'h0, 1, st, d0, d1);
        check("m0_write_latency", d0 - st, 2);
        check("pio_after_write", {50'd0, pio}, 64'h2A5);

        // m1 reads back the value
        run_round(0, 0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0, st, d0, d1);

        // tie: m0 first (last granted m1), m1 three cycles later
        run_round(1, 0, 2'd0, 32'h0, 1, 0, 2'd0, 32'h0, 0, st, d0, d1);
        check("tie_m0_latency", d0 - st, 2);
        check("tie_m1_latency", d1 - st, 5);

        // both held continuously for four transfers: m0, m1, m0, m1
        push_exp(1'b0, 0, 2'd0, 0); push_exp(1'b1, 0, 2'd0, 0);
        push_exp(1'b0, 0, 2'd0, 0); push_exp(1'b1, 0, 2'd0, 0);
        m0_read = 1; m1_read = 1; m0_address = 0; m1_address = 0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 4; i++) begin
            @(negedge clk);
            if (!m0_waitrequest || !m1_waitrequest) cnt++;
        end
        check("held_transfer_count", cnt, 4);
        @(negedge clk);
        m0_read = 0; m1_read = 0;

        // full-scale value, then read of the undecoded address 1 and of address 0
        run_round(0, 1, 2'd0, 32'hFFFF_FFFF, 0, 0, 2'd0, 0, 1, st, d0, d1);
        run_round(1, 0, 2'd1, 32'h0, 0, 0, 2'd0, 0, 0, st, d0, d1);
        run_round(0, 0, 2'd0, 32'h0, 1, 0, 2'd0, 0, 0, st, d0, d1);

        // read and write together act as a write
        run_round(1, 1, 2'd0, 32'h1, 0, 0, 2'd0, 0, 1, st, d0, d1);
        check("pio_after_rdwr", {50'd0, pio}, 64'h1);

        // reset in the middle of an m1 write's ISSUE cycle
        m1_write = 1; m1_address = 0; m1_writedata = 32'h1234;
        @(negedge clk);
        check("mid_issue_state", {62'd0, dbg_state}, {62'd0, ISSUE});
        reset = 1;
        @(negedge clk);
        check_reset_outputs();
        reset = 0; m1_write = 0;
        m_last = 1'b1; m_pio = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abandoned_m1_wait", {63'd0, m1_waitrequest}, 1);
        end
        run_round(0, 1, 2'd0, 32'h55, 0, 1, 2'd0, 32'h66, 0, st, d0, d1);
        check("post_reset_tie_m0", d0 - st, 2);
        check("post_reset_tie_m1", d1 - st, 5);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            int pat, op0, op1;
            pat = $urandom_range(1, 3);
            op0 = $urandom_range(0, 2);
            op1 = $urandom_range(0, 2);
            run_round(pat[0] && op0 != 1, pat[0] && op0 != 0, 2'($urandom_range(0, 3)), $urandom,
                      pat[1] && op1 != 1, pat[1] && op1 != 0, 2'($urandom_range(0, 3)), $urandom,
                      0, st, d0, d1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("exp_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
